// File: rtl/lstm_pkg.sv
// Shared definitions for the LSTM x-memory loader: FSM state encoding and frame sizing.
package lstm_pkg;

  typedef enum logic [1:0] {
    XL_IDLE  = 2'd0,
    XL_LOAD  = 2'd1,
    XL_DRAIN = 2'd2,
    XL_WAIT  = 2'd3
  } xl_state_e;

  function automatic int frame_len(input int timestep, input int features);
    return timestep * features;
  endfunction

endpackage

// File: rtl/lstm_x_loader_if.sv
// Stream, x-memory write and frame-handshake signals of lstm_x_loader.
// LSTM_XLOAD_STATS_EN adds the frame_cnt/drop_cnt statistics outputs.
interface lstm_x_loader_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 12
);
  logic [WIDTH-1:0]      s_data;
  logic                  s_valid;
  logic                  s_last;
  logic                  s_ready;
  logic                  wr_x1;
  logic [ADDR_WIDTH-1:0] wr_addr_x1;
  logic [WIDTH-1:0]      wr_data_x1;
  logic                  frame_valid;
  logic                  rd_bank;
  logic                  frame_done;
  logic                  err_frame;
`ifdef LSTM_XLOAD_STATS_EN
  logic [15:0]           frame_cnt;
  logic [7:0]            drop_cnt;
`endif

  // Loader side: sink of the sample stream, source of memory writes and frame status.
  modport slave (
    input  s_data, s_valid, s_last, frame_done,
    output s_ready, wr_x1, wr_addr_x1, wr_data_x1, frame_valid, rd_bank, err_frame
`ifdef LSTM_XLOAD_STATS_EN
    , output frame_cnt, drop_cnt
`endif
  );

  modport master (
    output s_data, s_valid, s_last, frame_done,
    input  s_ready, wr_x1, wr_addr_x1, wr_data_x1, frame_valid, rd_bank, err_frame
`ifdef LSTM_XLOAD_STATS_EN
    , input frame_cnt, drop_cnt
`endif
  );

endinterface

// File: rtl/lstm_xload_bank_ctrl.sv
// Ping-pong bank bookkeeping: which bank is written, which is read, and which hold full frames.
module lstm_xload_bank_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       complete_i,
  input  logic       done_i,
  output logic       wb_o,
  output logic       rd_bank_o,
  output logic [1:0] full_o,
  output logic       done_ok_o
);

  logic [1:0] full_q, full_d;
  logic       wb_q, wb_d;
  logic       rd_q, rd_d;

  // frame_done only counts while the read bank actually holds a frame.
  assign done_ok_o = done_i && full_q[rd_q];

  always_comb begin
    full_d = full_q;
    wb_d   = wb_q;
    rd_d   = rd_q;
    if (complete_i) begin
      full_d[wb_q] = 1'b1;
      wb_d         = ~wb_q;
    end
    if (done_ok_o) begin
      full_d[rd_q] = 1'b0;
      rd_d         = ~rd_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q <= 2'b00;
      wb_q   <= 1'b0;
      rd_q   <= 1'b0;
    end else begin
      full_q <= full_d;
      wb_q   <= wb_d;
      rd_q   <= rd_d;
    end
  end

  assign wb_o      = wb_q;
  assign rd_bank_o = rd_q;
  assign full_o    = full_q;

endmodule

// File: rtl/lstm_x_loader.sv
// Loads TIMESTEP x LAYR1_INPUT word samples into the ping-pong layer-1 x memory.
// Define LSTM_XLOAD_STATS_EN to add saturating frame_cnt/drop_cnt outputs.
module lstm_x_loader
  import lstm_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int TIMESTEP    = 7,
  parameter int LAYR1_INPUT = 53,
  parameter int BANK_OFFSET = 512
) (
  input  logic          clk,
  input  logic          rst,
  lstm_x_loader_if.slave bus
);

  localparam int                    FRAME_LEN  = frame_len(TIMESTEP, LAYR1_INPUT);
  localparam int                    CNT_W      = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(FRAME_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] BANK1_BASE = ADDR_WIDTH'(BANK_OFFSET);

  xl_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      data_q, data_d;
  logic                  err_q, err_d;
  logic                  complete, drop;
  logic                  wb, rd_bank, done_ok;
  logic [1:0]            bank_full;
  logic                  s_ready, accept, next_busy;

  lstm_xload_bank_ctrl u_bank (
    .clk        (clk),
    .rst        (rst),
    .complete_i (complete),
    .done_i     (bus.frame_done),
    .wb_o       (wb),
    .rd_bank_o  (rd_bank),
    .full_o     (bank_full),
    .done_ok_o  (done_ok)
  );

  assign s_ready = (state_q == XL_DRAIN) || ((state_q == XL_LOAD) && !bank_full[wb]);
  assign accept  = bus.s_valid && s_ready;
  // Bank we switch to on completion, accounting for a release of it in the same cycle.
  assign next_busy = bank_full[~wb] && !(done_ok && (rd_bank != wb));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    err_d    = err_q;
    complete = 1'b0;
    drop     = 1'b0;
    case (state_q)
      XL_IDLE: state_d = XL_LOAD;
      XL_LOAD: begin
        if (accept) begin
          wr_d   = 1'b1;
          addr_d = (wb ? BANK1_BASE : '0) + ADDR_WIDTH'(cnt_q);
          data_d = bus.s_data;
          cnt_d  = '0;
          if (cnt_q == CNT_LAST) begin
            if (bus.s_last) begin
              complete = 1'b1;
              state_d  = next_busy ? XL_WAIT : XL_LOAD;
            end else begin
              drop    = 1'b1;
              err_d   = 1'b1;
              state_d = XL_DRAIN;
            end
          end else if (bus.s_last) begin
            drop  = 1'b1;
            err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      XL_DRAIN: begin
        if (accept && bus.s_last) begin
          state_d = XL_LOAD;
          cnt_d   = '0;
        end
      end
      XL_WAIT: begin
        if (!bank_full[wb]) state_d = XL_LOAD;
      end
      default: state_d = XL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= XL_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign bus.s_ready     = s_ready;
  assign bus.wr_x1       = wr_q;
  assign bus.wr_addr_x1  = addr_q;
  assign bus.wr_data_x1  = data_q;
  assign bus.frame_valid = bank_full[rd_bank];
  assign bus.rd_bank     = rd_bank;
  assign bus.err_frame   = err_q;

`ifdef LSTM_XLOAD_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [7:0]  drop_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (complete && (frame_cnt_q != '1)) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (drop && (drop_cnt_q != '1))      drop_cnt_q  <= drop_cnt_q + 8'd1;
    end
  end

  assign bus.frame_cnt = frame_cnt_q;
  assign bus.drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_lstm_x_loader.sv
// Bench for lstm_x_loader: directed sequences, a frame vector table and a randomized run.
module tb_lstm_x_loader;

  localparam int W  = 32;
  localparam int AW = 12;
  localparam int FL = 371;
  localparam int BO = 512;

  typedef struct { int addr; logic [W-1:0] data; } wr_t;
  typedef struct { int nwords; logic [W-1:0] dbase; int exp_nwr; int exp_addr0; bit exp_fv; bit exp_err; } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lstm_x_loader_if #(.WIDTH(W), .ADDR_WIDTH(AW)) ifc ();

  lstm_x_loader #(.WIDTH(W), .ADDR_WIDTH(AW), .TIMESTEP(7), .LAYR1_INPUT(53), .BANK_OFFSET(BO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int checks = 0;
  int failures = 0;
  logic [W-1:0] obs_mem [0:4095];
  wr_t wr_log[$];

  always @(negedge clk) begin
    if (ifc.wr_x1 === 1'b1) begin
      obs_mem[ifc.wr_addr_x1] = ifc.wr_data_x1;
      wr_log.push_back('{int'(ifc.wr_addr_x1), ifc.wr_data_x1});
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [W-1:0] d, input logic l, input int gap_pct);
    int n;
    while (gap_pct > 0 && $urandom_range(99) < gap_pct) tick();
    ifc.s_valid = 1'b1;
    ifc.s_data  = d;
    ifc.s_last  = l;
    n = 0;
    while (ifc.s_ready !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) chk("ready_timeout", ifc.s_ready, 1);
    tick();
    ifc.s_valid = 1'b0;
    ifc.s_last  = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [W-1:0] base, input int gap_pct);
    for (int i = 0; i < n; i++) beat(base + W'(i), (i == n - 1), gap_pct);
  endtask

  task automatic pulse_done();
    ifc.frame_done = 1'b1;
    tick();
    ifc.frame_done = 1'b0;
  endtask

  task automatic chk_writes(input string nm, input int start, input int n_exp, input int addr0, input logic [W-1:0] data0);
    int got, errs;
    got  = wr_log.size() - start;
    errs = 0;
    chk({nm, "_nwr"}, got, n_exp);
    for (int i = 0; i < got && i < n_exp; i++)
      if (wr_log[start+i].addr != addr0 + i || wr_log[start+i].data !== data0 + W'(i)) errs++;
    chk({nm, "_seq"}, errs, 0);
  endtask

  vec_t tbl[7];
  logic [W-1:0] good_q[$];
  bit driver_done;
  int n_good, n_drop, exp_wr, s;

  initial begin
    tbl[0] = '{371, 32'd100, 371, 0,   1'b1, 1'b0};
    tbl[1] = '{100, 32'd200, 100, 512, 1'b0, 1'b1};
    tbl[2] = '{371, 32'd300, 371, 512, 1'b1, 1'b1};
    tbl[3] = '{376, 32'd400, 371, 0,   1'b0, 1'b1};
    tbl[4] = '{371, 32'd500, 371, 0,   1'b1, 1'b1};
    tbl[5] = '{1,   32'd600, 1,   512, 1'b0, 1'b1};
    tbl[6] = '{371, 32'd700, 371, 512, 1'b1, 1'b1};

    ifc.s_valid = 1'b0; ifc.s_last = 1'b0; ifc.s_data = '0; ifc.frame_done = 1'b0;
    rst = 1'b0;
    tick();
    chk("rst_s_ready", ifc.s_ready, 0);
    chk("rst_wr_x1", ifc.wr_x1, 0);
    chk("rst_wr_addr", ifc.wr_addr_x1, 0);
    chk("rst_wr_data", ifc.wr_data_x1, 0);
    chk("rst_frame_valid", ifc.frame_valid, 0);
    chk("rst_rd_bank", ifc.rd_bank, 0);
    chk("rst_err", ifc.err_frame, 0);
    rst = 1'b1;
    #1;
    chk("idle_s_ready", ifc.s_ready, 0);
    tick();

    // First frame into bank 0, second into bank 1, then the loader must stall.
    s = wr_log.size();
    send_frame(FL, 32'd0, 0);
    tick(); tick();
    chk_writes("f0", s, FL, 0, 32'd0);
    chk("f0_fv", ifc.frame_valid, 1);
    chk("f0_rd_bank", ifc.rd_bank, 0);
    s = wr_log.size();
    send_frame(FL, 32'd1000, 0);
    tick(); tick();
    chk_writes("f1", s, FL, BO, 32'd1000);
    repeat (3) tick();
    chk("full_s_ready", ifc.s_ready, 0);
    pulse_done();
    chk("done0_rd_bank", ifc.rd_bank, 1);
    chk("done0_fv", ifc.frame_valid, 1);
    tick();
    chk("done0_s_ready", ifc.s_ready, 1);
    pulse_done();
    chk("done1_rd_bank", ifc.rd_bank, 0);
    chk("done1_fv", ifc.frame_valid, 0);
    pulse_done();
    chk("idle_done_rd_bank", ifc.rd_bank, 0);

    // Vector table: good, short and overlong frames.
    for (int k = 0; k < 7; k++) begin
      s = wr_log.size();
      send_frame(tbl[k].nwords, tbl[k].dbase, 0);
      tick(); tick();
      chk_writes($sformatf("tbl%0d", k), s, tbl[k].exp_nwr, tbl[k].exp_addr0, tbl[k].dbase);
      chk($sformatf("tbl%0d_fv", k), ifc.frame_valid, tbl[k].exp_fv);
      chk($sformatf("tbl%0d_err", k), ifc.err_frame, tbl[k].exp_err);
      if (tbl[k].exp_fv) begin
        chk($sformatf("tbl%0d_rd_bank", k), ifc.rd_bank, tbl[k].exp_addr0 / BO);
        pulse_done();
        chk($sformatf("tbl%0d_fv_clr", k), ifc.frame_valid, 0);
      end
    end

    // Reset in the middle of a frame.
    for (int i = 0; i < 200; i++) beat(32'd3000 + W'(i), 1'b0, 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_wr_x1", ifc.wr_x1, 0);
    chk("mid_rst_wr_addr", ifc.wr_addr_x1, 0);
    chk("mid_rst_wr_data", ifc.wr_data_x1, 0);
    chk("mid_rst_s_ready", ifc.s_ready, 0);
    chk("mid_rst_err", ifc.err_frame, 0);
    chk("mid_rst_fv", ifc.frame_valid, 0);
    tick();
    rst = 1'b1;
    tick();
    s = wr_log.size();
    send_frame(FL, 32'd5000, 0);
    tick(); tick();
    chk_writes("post_rst", s, FL, 0, 32'd5000);
    chk("post_rst_fv", ifc.frame_valid, 1);
    chk("post_rst_rd_bank", ifc.rd_bank, 0);

    // Randomized traffic against a frame-level model.
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    s = wr_log.size();
    n_good = 0; n_drop = 0; exp_wr = 0; driver_done = 1'b0;
    fork
      begin
        for (int f = 0; f < 30; f++) begin
          int kind, n;
          logic [W-1:0] base;
          kind = (f == 2) ? 0 : (f == 5) ? 1 : int'($urandom_range(9));
          n    = (kind == 0) ? int'($urandom_range(370, 1)) : (kind == 1) ? int'($urandom_range(380, 372)) : FL;
          base = $urandom;
          if (n == FL) begin
            good_q.push_back(base);
            n_good++;
          end else begin
            n_drop++;
          end
          exp_wr += (n < FL) ? n : FL;
          send_frame(n, base, 15);
        end
        driver_done = 1'b1;
      end
      begin
        int cyc, consumed, errs;
        logic rb;
        logic [W-1:0] b;
        cyc = 0; consumed = 0;
        while (!(driver_done && good_q.size() == 0) && cyc < 60000) begin
          tick();
          cyc++;
          if (ifc.frame_valid === 1'b1) begin
            @(negedge clk);
            #1;
            if (good_q.size() == 0) begin
              chk("rand_spurious_fv", ifc.frame_valid, 0);
            end else begin
              b = good_q.pop_front();
              errs = 0;
              for (int i = 0; i < FL; i++)
                if (obs_mem[int'(ifc.rd_bank) * BO + i] !== b + W'(i)) errs++;
              chk("rand_frame_data", errs, 0);
              chk("rand_rd_bank", ifc.rd_bank, consumed % 2);
              consumed++;
            end
            repeat ($urandom_range(40)) tick();
            pulse_done();
          end else if ($urandom_range(19) == 0) begin
            rb = ifc.rd_bank;
            pulse_done();
            chk("rand_idle_done", ifc.rd_bank, rb);
          end
        end
        if (cyc >= 60000) chk("consumer_timeout", good_q.size(), 0);
      end
    join
    chk("rand_total_writes", wr_log.size() - s, exp_wr);
    chk("rand_err", ifc.err_frame, (n_drop > 0));
`ifdef LSTM_XLOAD_STATS_EN
    chk("rand_frame_cnt", ifc.frame_cnt, n_good);
    chk("rand_drop_cnt", ifc.drop_cnt, n_drop);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
